// File: rtl/aes_bist_pkg.sv
// Shared definitions for the AES known-answer BIST: vector tables, FSM encoding,
// tag format and the MISR step used when AES_BIST_MISR_EN is defined.
package aes_bist_pkg;

  localparam int         NUM_KAT  = 5;
  localparam logic [2:0] NONE_IDX = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } tag_t;

  typedef struct packed {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } kat_t;

  localparam logic [127:0] KAT_PT [NUM_KAT] = '{
    128'h3243f6a8885a308d313198a2e0370734,
    128'h00112233445566778899aabbccddeeff,
    128'h0,
    128'h0,
    128'h1
  };

  localparam logic [127:0] KAT_KEY [NUM_KAT] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'h000102030405060708090a0b0c0d0e0f,
    128'h0,
    128'h1,
    128'h0
  };

  localparam logic [127:0] KAT_CT [NUM_KAT] = '{
    128'h3925841d02dc09fbdc118597196a0b32,
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
    128'h0545aad56da2a97c3663d1432a3d1c84,
    128'h58e2fccefa7e3061367f1d57a4e7455a
  };

  // Shift left with feedback taps 127/126/125/120, then fold in the new word.
  function automatic logic [127:0] misr_next(input logic [127:0] sig,
                                             input logic [127:0] din);
    return {sig[126:0], sig[127] ^ sig[126] ^ sig[125] ^ sig[120]} ^ din;
  endfunction

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational lookup of one known-answer vector; indices past the table read as zero.
module aes_kat_rom
  import aes_bist_pkg::*;
(
  input  logic [2:0] idx_i,
  output kat_t       kat_o
);

  always_comb begin
    kat_o = '0;
    for (int i = 0; i < NUM_KAT; i++) begin
      if (idx_i == 3'(i)) begin
        kat_o.pt  = KAT_PT[i];
        kat_o.key = KAT_KEY[i];
        kat_o.ct  = KAT_CT[i];
      end
    end
  end

endmodule

// File: rtl/aes_kat_bist.sv
// Known-answer self-test for the pipelined AES-128 core: issues NUM_VEC vectors back to
// back and checks each result LATENCY cycles later. Optional MISR port: AES_BIST_MISR_EN.
module aes_kat_bist
  import aes_bist_pkg::*;
#(
  parameter int NUM_VEC = 5,
  parameter int LATENCY = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [127:0] aes_state,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [2:0]   fail_count,
  output logic [2:0]   first_fail_idx
`ifdef AES_BIST_MISR_EN
  ,
  output logic [127:0] signature
`endif
);

  state_t       state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] key_q, key_d;
  logic [2:0]   fail_q, fail_d;
  logic [2:0]   first_q, first_d;
  logic         pass_q, pass_d;
  tag_t         tag_q [LATENCY];
  tag_t         tag_in;
  tag_t         tag_out;

  logic [2:0]   issue_idx;
  kat_t         kat_iss;
  kat_t         kat_cmp;
  logic         start_ok;
  logic         mismatch;

  // Issue side looks one vector ahead so the output registers hold vector k in cycle 1+k.
  assign issue_idx = (state_q == ST_ISSUE) ? idx_q + 3'd1 : 3'd0;
  assign tag_out   = tag_q[LATENCY-1];

  aes_kat_rom u_rom_issue (.idx_i(issue_idx),   .kat_o(kat_iss));
  aes_kat_rom u_rom_cmp   (.idx_i(tag_out.idx), .kat_o(kat_cmp));

  logic unused_rom_bits;
  assign unused_rom_bits = ^{kat_iss.ct, kat_cmp.pt, kat_cmp.key};

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch = tag_out.valid && (aes_out != kat_cmp.ct);

  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    pt_d    = '0;
    key_d   = '0;
    tag_in  = '0;
    fail_d  = fail_q;
    first_d = first_q;
    pass_d  = pass_q;

    if (mismatch) begin
      if (fail_q != 3'd7)        fail_d  = fail_q + 3'd1;
      if (first_q == NONE_IDX)   first_d = tag_out.idx;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = ST_ISSUE;
          idx_d   = 3'd0;
          pt_d    = kat_iss.pt;
          key_d   = kat_iss.key;
          fail_d  = 3'd0;
          first_d = NONE_IDX;
          pass_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tag_in = '{valid: 1'b1, idx: idx_q};
        if (idx_q == 3'(NUM_VEC - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 3'd1;
          pt_d  = kat_iss.pt;
          key_d = kat_iss.key;
        end
      end
      ST_DRAIN: begin
        if (tag_out.valid && (tag_out.idx == 3'(NUM_VEC - 1))) begin
          state_d = ST_DONE;
          pass_d  = (fail_d == 3'd0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      pt_q    <= '0;
      key_q   <= '0;
      fail_q  <= 3'd0;
      first_q <= NONE_IDX;
      pass_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its inputs.
      state_q <= state_d;
      idx_q   <= idx_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  // NOTE: the tag pipe is reset because a stale valid tag after an aborted run
  // would score a bogus compare; the ciphertext datapath itself needs no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

`ifdef AES_BIST_MISR_EN
  logic [127:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (start_ok)           sig_d = '0;
    else if (tag_out.valid) sig_d = misr_next(sig_q, aes_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign signature = sig_q;
`endif

  assign aes_state      = pt_q;
  assign aes_key        = key_q;
  assign busy           = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_idx = first_q;

endmodule

// File: tb/tb_aes_kat_bist.sv
// Bench for aes_kat_bist: a default instance and a NUM_VEC=1/LATENCY=1 instance, each
// driven by a behavioural core that returns stored answers with optional bit-0 corruption.
module tb_aes_kat_bist;

  localparam int LAT0 = 21;
  localparam int NV0  = 5;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
  } vec_t;

  typedef struct {
    logic       pass;
    logic [2:0] fc;
    logic [2:0] ffi;
  } res_t;

  typedef struct {
    logic [4:0] mask;
    int         restart_at;
    bit         chain;
    logic       exp_pass;
    logic [2:0] exp_fc;
    logic [2:0] exp_ffi;
  } run_t;

  logic [127:0] tb_pt  [5];
  logic [127:0] tb_key [5];
  logic [127:0] tb_ct  [5];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic [4:0] mask0 = 5'd0;

  logic [127:0] st0, key0, out0, st1, key1, out1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [2:0] fc0, ffi0, fc1, ffi1;
`ifdef AES_BIST_MISR_EN
  logic [127:0] sig0, sig1;
`endif

  int errors = 0;
  int checks = 0;
  vec_t vec_q[$];
  res_t res_q[$];

  always #5 clk = ~clk;

  aes_kat_bist #(.NUM_VEC(NV0), .LATENCY(LAT0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .aes_state(st0), .aes_key(key0), .aes_out(out0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .first_fail_idx(ffi0)
`ifdef AES_BIST_MISR_EN
    , .signature(sig0)
`endif
  );

  aes_kat_bist #(.NUM_VEC(1), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .aes_state(st1), .aes_key(key1), .aes_out(out1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_idx(ffi1)
`ifdef AES_BIST_MISR_EN
    , .signature(sig1)
`endif
  );

  function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] key,
                                            input logic [4:0] mask);
    for (int i = 0; i < 5; i++)
      if (pt == tb_pt[i] && key == tb_key[i]) return tb_ct[i] ^ {127'd0, mask[i]};
    return 128'd0;
  endfunction

  logic [127:0] core0 [LAT0];
  logic [127:0] core1;

  always @(posedge clk) begin
    core0[0] <= model_ct(st0, key0, mask0);
    for (int i = 1; i < LAT0; i++) core0[i] <= core0[i-1];
    core1 <= model_ct(st1, key1, 5'd0);
  end
  assign out0 = core0[LAT0-1];
  assign out1 = core1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input run_t r, input bit pre);
    bit   seen;
    vec_t v;
    res_t e;
    mask0 = r.mask;
    if (!pre) begin
      @(negedge clk);
      start0 = 1'b1;
    end
    for (int k = 0; k < NV0; k++) vec_q.push_back('{pt: tb_pt[k], key: tb_key[k]});
    res_q.push_back('{pass: r.exp_pass, fc: r.exp_fc, ffi: r.exp_ffi});
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) start0 = 1'b0;
      if (r.restart_at != 0) begin
        if (c == r.restart_at)          start0 = 1'b1;
        else if (c == r.restart_at + 1) start0 = 1'b0;
      end
      if (c <= NV0 && vec_q.size() > 0) begin
        v = vec_q.pop_front();
        check($sformatf("aes_state[%0d]", c - 1), st0, v.pt);
        check($sformatf("aes_key[%0d]", c - 1), key0, v.key);
      end
      if (c == 1 || c == NV0 + LAT0) check("busy_in_run", busy0, 1'b1);
      if (done0) begin
        seen = 1'b1;
        e = res_q.pop_front();
        check("done_cycle", c, NV0 + LAT0 + 1);
        check("pass", pass0, e.pass);
        check("fail_count", fc0, e.fc);
        check("first_fail_idx", ffi0, e.ffi);
        check("busy_at_done", busy0, 1'b0);
        if (r.chain) start0 = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 40 cycles, required cycle %0d", NV0 + LAT0 + 1);
      if (res_q.size() > 0) void'(res_q.pop_front());
      vec_q.delete();
      start0 = 1'b0;
    end else if (!r.chain) begin
      @(negedge clk);
      check("done_is_pulse", done0, 1'b0);
      check("pass_held", pass0, e.pass);
      check("fail_count_held", fc0, e.fc);
      check("first_fail_idx_held", ffi0, e.ffi);
    end
  endtask

  run_t runs [7];

  initial begin
    bit prev_chain;

    tb_pt[0]  = 128'h3243f6a8885a308d313198a2e0370734;
    tb_key[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tb_ct[0]  = 128'h3925841d02dc09fbdc118597196a0b32;
    tb_pt[1]  = 128'h00112233445566778899aabbccddeeff;
    tb_key[1] = 128'h000102030405060708090a0b0c0d0e0f;
    tb_ct[1]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    tb_pt[2]  = 128'h0;
    tb_key[2] = 128'h0;
    tb_ct[2]  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    tb_pt[3]  = 128'h0;
    tb_key[3] = 128'h1;
    tb_ct[3]  = 128'h0545aad56da2a97c3663d1432a3d1c84;
    tb_pt[4]  = 128'h1;
    tb_key[4] = 128'h0;
    tb_ct[4]  = 128'h58e2fccefa7e3061367f1d57a4e7455a;

    //            mask      restart chain pass fc    ffi
    runs[0] = '{5'b00000, 0,  1'b0, 1'b1, 3'd0, 3'd7};
    runs[1] = '{5'b00100, 0,  1'b0, 1'b0, 3'd1, 3'd2};
    runs[2] = '{5'b00000, 10, 1'b1, 1'b1, 3'd0, 3'd7};
    runs[3] = '{5'b00001, 0,  1'b0, 1'b0, 3'd1, 3'd0};
    runs[4] = '{5'b11111, 0,  1'b0, 1'b0, 3'd5, 3'd0};
    runs[5] = '{5'b01100, 0,  1'b0, 1'b0, 3'd2, 3'd2};
    runs[6] = '{5'b10000, 0,  1'b0, 1'b0, 3'd1, 3'd4};

    repeat (3) @(negedge clk);
    check("rst_aes_state", st0, 128'd0);
    check("rst_aes_key", key0, 128'd0);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_pass", pass0, 1'b0);
    check("rst_fail_count", fc0, 3'd0);
    check("rst_first_fail_idx", ffi0, 3'd7);
    check("rst1_first_fail_idx", ffi1, 3'd7);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    prev_chain = 1'b0;
    foreach (runs[i]) begin
      run(runs[i], prev_chain);
      prev_chain = runs[i].chain;
    end

    // Abort a run with reset in cycle 12, then confirm a fresh run is clean.
    mask0 = 5'b00000;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (11) @(negedge clk);
    check("busy_before_abort", busy0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy0, 1'b0);
    check("abort_aes_state", st0, 128'd0);
    check("abort_first_fail_idx", ffi0, 3'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", done0, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check("abort_no_late_done", done0, 1'b0);
    end
    run(runs[0], 1'b0);

    // Minimal configuration: one vector, one-cycle core.
    @(negedge clk);
    start1 = 1'b1;
    begin
      bit seen1;
      seen1 = 1'b0;
      for (int c = 1; c <= 10 && !seen1; c++) begin
        @(negedge clk);
        if (c == 1) begin
          start1 = 1'b0;
          check("min_aes_state", st1, tb_pt[0]);
          check("min_aes_key", key1, tb_key[0]);
        end
        if (done1) begin
          seen1 = 1'b1;
          check("min_done_cycle", c, 3);
          check("min_pass", pass1, 1'b1);
          check("min_fail_count", fc1, 3'd0);
          check("min_first_fail_idx", ffi1, 3'd7);
`ifdef AES_BIST_MISR_EN
          check("min_signature", sig1, tb_ct[0]);
`endif
        end
      end
      if (!seen1) begin
        checks++;
        errors++;
        $display("FAIL min_done_timeout: got no done within 10 cycles, required cycle 3");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
